cube_shader: RTL
================

CUBE_SHADER -- requirements
Module: cube_shader

Interface
REQ-001 SHALL have parameter N_cube, default 28, the number of cubes whose face flags are merged.
REQ-002 SHALL have parameter FLASH_FRAMES, default 16, the number of frames per flash phase.
REQ-003 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 x_cnt  input  11  current pixel column from the display timing.
REQ-006 y_cnt  input  10  current pixel row from the display timing.
REQ-007 pix_valid  input  1  active-video qualifier for the current x_cnt/y_cnt.
REQ-008 top_face, left_face, right_face  input  N_cube each  per-cube face hit flags for the current pixel.
REQ-009 top_color  input  N_cube  per-cube visited flag (1 = visited colour).
REQ-010 pal_wr  input  1  palette write request.
REQ-011 pal_addr  input  3  palette entry index.
REQ-012 pal_data  input  24  palette RGB888 value.
REQ-013 pal_ready  output  1  palette write accept.
REQ-014 level_done  input  1  single-cycle pulse that starts the level-complete flash.
REQ-015 rgb  output  24  pixel colour.
REQ-016 rgb_valid  output  1  qualifier for rgb.
REQ-017 flash_busy  output  1  high while the flash sequence runs.
REQ-018 flash_done  output  1  one-cycle pulse at the end of the flash sequence.

Function
REQ-019 Cube select: the cube with the highest index that has any face flag set SHALL win the pixel.
REQ-020 Face precedence within the winning cube SHALL be top, then left, then right.
REQ-021 No cube hit SHALL produce the background colour.
REQ-022 Pipeline stage 1 SHALL register the face code (NONE/TOP/LEFT/RIGHT), the winner's top_color bit and pix_valid.
REQ-023 Pipeline stage 2 SHALL perform the palette lookup into rgb and register rgb_valid.
REQ-024 Fixed latency: rgb/rgb_valid SHALL correspond to the inputs sampled 2 cycles earlier.
REQ-025 rgb SHALL be 24'h000000 whenever the delayed pix_valid is 0.
REQ-026 Palette entries: 0 = BG, 1 = LEFT, 2 = RIGHT, 3 = TOP_UNVISITED, 4 = TOP_VISITED, 5 = FLASH_ALT.
REQ-027 A palette write occurs when pal_wr and pal_ready are both 1.
REQ-028 pal_addr values 6 and 7 SHALL be accepted on the handshake and discarded.
REQ-029 pal_ready SHALL be 1 except in the FLASH state; a write presented in FLASH SHALL wait.
REQ-030 A written palette value SHALL be used by stage-2 lookups from the following cycle onward; a lookup in the write cycle uses the old value.
REQ-031 Frame tick: a single-cycle event on x_cnt==0 && y_cnt==0 that was not also true on the previous cycle.
REQ-032 FSM IDLE: level_done moves the FSM to FLASH and clears the frame counter (4 bits) and the phase counter (3 bits).
REQ-033 FSM FLASH: each frame tick increments the frame counter.
REQ-034 FSM FLASH: when the frame counter reaches FLASH_FRAMES-1 on a tick, it wraps to 0 and the phase counter increments.
REQ-035 FSM FLASH: at phase 7 with the frame counter wrap, the FSM returns to IDLE and pulses flash_done for one cycle.
REQ-036 In FLASH with phase[0]==1, TOP pixels SHALL use FLASH_ALT regardless of top_color; otherwise the normal colours apply.
REQ-037 level_done while in FLASH SHALL be ignored, with no restart.
REQ-038 level_done coincident with a frame tick in IDLE SHALL enter FLASH; that tick SHALL NOT be counted.
REQ-039 flash_busy SHALL be 1 exactly while the FSM is in FLASH.

Reset
REQ-040 On reset the FSM SHALL be IDLE, all counters 0, and all pipeline registers cleared.
REQ-041 Output values during reset: rgb = 0, rgb_valid = 0, flash_busy = 0, flash_done = 0, pal_ready = 1.
REQ-042 On reset the palette SHALL load its defaults: BG 000000, LEFT 3C3C64, RIGHT 1E1E3C, TOP_UNVISITED D2B464, TOP_VISITED 2860C8, FLASH_ALT FFFFFF.
REQ-043 Reset asserted mid-flash SHALL abort the flash without a flash_done pulse.

Structure
REQ-044 A shared package qbert_pkg SHALL hold the face_t enum, the palette index constants, the default colours and the flash state enum.
REQ-045 The per-pixel priority selection SHALL be implemented as one combinational sub-module, cube_face_select.

Verification
REQ-046 Bench SHALL cover: cube 3 top (top_color=0) and cube 7 left set, pix_valid=1 -> 2 cycles later rgb=3C3C64, rgb_valid=1.
REQ-047 Bench SHALL cover: same cube with top and right set, top_color=1 -> rgb=2860C8; with no flags set -> rgb=000000 (BG).
REQ-048 Bench SHALL cover: pal_wr with addr 1 = 00FF00 while streaming LEFT pixels -> write-cycle pixel shows old colour, the next shows 00FF00; addr 6 write -> palette unchanged.
REQ-049 Bench SHALL cover: level_done, then 16 frame ticks -> phase 1, TOP pixels = FFFFFF, pal_ready=0; after 128 ticks -> flash_done single pulse, flash_busy=0.
REQ-050 Bench SHALL cover: second level_done during FLASH -> completion tick count unchanged (128); reset at tick 40 -> IDLE, no flash_done, palette back to defaults.

Source files
------------

// File: rtl/qbert_pkg.sv
// Shared types and constants for the Q*bert cube shader: face codes, palette layout,
// default colours and the level-complete flash states.
package qbert_pkg;

    typedef enum logic [1:0] {
        FaceNone,
        FaceTop,
        FaceLeft,
        FaceRight
    } face_t;

    typedef enum logic {
        StIdle,
        StFlash
    } flash_state_t;

    localparam int unsigned PalEntries = 6;

    localparam logic [2:0] PalBg       = 3'd0;
    localparam logic [2:0] PalLeft     = 3'd1;
    localparam logic [2:0] PalRight    = 3'd2;
    localparam logic [2:0] PalTopUnvis = 3'd3;
    localparam logic [2:0] PalTopVis   = 3'd4;
    localparam logic [2:0] PalFlashAlt = 3'd5;

    localparam logic [23:0] ColBg       = 24'h000000;
    localparam logic [23:0] ColLeft     = 24'h3C3C64;
    localparam logic [23:0] ColRight    = 24'h1E1E3C;
    localparam logic [23:0] ColTopUnvis = 24'hD2B464;
    localparam logic [23:0] ColTopVis   = 24'h2860C8;
    localparam logic [23:0] ColFlashAlt = 24'hFFFFFF;

    function automatic logic [23:0] pal_default(input logic [2:0] idx);
        unique case (idx)
            PalBg:       pal_default = ColBg;
            PalLeft:     pal_default = ColLeft;
            PalRight:    pal_default = ColRight;
            PalTopUnvis: pal_default = ColTopUnvis;
            PalTopVis:   pal_default = ColTopVis;
            PalFlashAlt: pal_default = ColFlashAlt;
            default:     pal_default = ColBg;
        endcase
    endfunction

endpackage

// File: rtl/cube_face_select.sv
// Per-pixel priority merge of all cube face flags: highest cube index wins,
// and within that cube top beats left beats right.
module cube_face_select
    import qbert_pkg::*;
#(
    parameter int unsigned N_cube = 28
) (
    input  logic [N_cube-1:0] top_face,
    input  logic [N_cube-1:0] left_face,
    input  logic [N_cube-1:0] right_face,
    input  logic [N_cube-1:0] top_color,
    output face_t             face,
    output logic              visited
);

    // Ascending scan so the last (highest-index) hit overrides lower ones.
    always_comb begin
        face    = FaceNone;
        visited = 1'b0;
        for (int i = 0; i < N_cube; i++) begin
            if (top_face[i]) begin
                face    = FaceTop;
                visited = top_color[i];
            end else if (left_face[i]) begin
                face    = FaceLeft;
                visited = top_color[i];
            end else if (right_face[i]) begin
                face    = FaceRight;
                visited = top_color[i];
            end
        end
    end

endmodule

// File: rtl/cube_shader.sv
// Two-stage cube pixel shader: face select, then palette lookup, with a writable
// palette and a frame-counted level-complete flash sequence.
module cube_shader
    import qbert_pkg::*;
#(
    parameter int unsigned N_cube       = 28,
    parameter int unsigned FLASH_FRAMES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       x_cnt,
    input  logic [9:0]        y_cnt,
    input  logic              pix_valid,
    input  logic [N_cube-1:0] top_face,
    input  logic [N_cube-1:0] left_face,
    input  logic [N_cube-1:0] right_face,
    input  logic [N_cube-1:0] top_color,
    input  logic              pal_wr,
    input  logic [2:0]        pal_addr,
    input  logic [23:0]       pal_data,
    output logic              pal_ready,
    input  logic              level_done,
    output logic [23:0]       rgb,
    output logic              rgb_valid,
    output logic              flash_busy,
    output logic              flash_done
);

    localparam logic [3:0] FrameLast = 4'(FLASH_FRAMES - 1);

    face_t        sel_face;
    logic         sel_visited;
    face_t        face_q;
    logic         visited_q, valid_q;
    logic [23:0]  rgb_q;
    logic         rgb_valid_q;
    logic [23:0]  pal_q [PalEntries];
    logic [2:0]   lut_idx;

    flash_state_t state_q, state_d;
    logic [3:0]   frame_q, frame_d;
    logic [2:0]   phase_q, phase_d;
    logic         done_q, done_d;
    logic         origin_prev_q;
    logic         at_origin, tick;

    cube_face_select #(
        .N_cube (N_cube)
    ) u_select (
        .top_face   (top_face),
        .left_face  (left_face),
        .right_face (right_face),
        .top_color  (top_color),
        .face       (sel_face),
        .visited    (sel_visited)
    );

    assign at_origin = (x_cnt == '0) && (y_cnt == '0);
    assign tick      = at_origin && !origin_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            face_q        <= FaceNone;
            visited_q     <= 1'b0;
            valid_q       <= 1'b0;
            origin_prev_q <= 1'b0;
        end else begin
            face_q        <= sel_face;
            visited_q     <= sel_visited;
            valid_q       <= pix_valid;
            origin_prev_q <= at_origin;
        end
    end

    always_comb begin
        lut_idx = PalBg;
        unique case (face_q)
            FaceNone:  lut_idx = PalBg;
            FaceLeft:  lut_idx = PalLeft;
            FaceRight: lut_idx = PalRight;
            FaceTop: begin
                if (state_q == StFlash && phase_q[0]) lut_idx = PalFlashAlt;
                else if (visited_q)                   lut_idx = PalTopVis;
                else                                  lut_idx = PalTopUnvis;
            end
        endcase
    end

    // Non-blocking palette update: a lookup in the write cycle still sees the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PalEntries; i++) pal_q[i] <= pal_default(3'(i));
        end else if (pal_wr && pal_ready && pal_addr <= PalFlashAlt) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= valid_q ? pal_q[lut_idx] : '0;
            rgb_valid_q <= valid_q;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A tick coinciding with the start is deliberately not counted.
                if (level_done) begin
                    state_d = StFlash;
                    frame_d = '0;
                    phase_d = '0;
                end
            end
            StFlash: begin
                if (tick) begin
                    if (frame_q == FrameLast) begin
                        frame_d = '0;
                        if (phase_q == 3'd7) begin
                            state_d = StIdle;
                            phase_d = '0;
                            done_d  = 1'b1;
                        end else begin
                            phase_d = phase_q + 3'd1;
                        end
                    end else begin
                        frame_d = frame_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            frame_q <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    assign rgb        = rgb_q;
    assign rgb_valid  = rgb_valid_q;
    assign flash_busy = (state_q == StFlash);
    assign pal_ready  = (state_q != StFlash);
    assign flash_done = done_q;

endmodule
